// File: rtl/inter_switch_sched.sv
// Route sequencer for inter_switch: queues validated route descriptors and
// drives the switch ctrl word one descriptor at a time, counting accepted beats.
module inter_switch_sched #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned BEAT_W     = 16,
    parameter int unsigned TAG_W      = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [TAG_W+BEAT_W+18-1:0]    s_cmd_tdata,
    input  logic                          s_cmd_tvalid,
    output logic                          s_cmd_tready,
    input  logic                          count_switch_tvalid,
    output logic [17:0]                   ctrl,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [TAG_W-1:0]              evt_tag
);

    localparam int unsigned ROUTE_W = 18;
    localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned OCC_W   = PTR_W + 1;

    typedef struct packed {
        logic [TAG_W-1:0]   tag;
        logic [BEAT_W-1:0]  beats;
        logic [ROUTE_W-1:0] route;
    } cmd_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    cmd_t               in_cmd;
    cmd_t               head;
    cmd_t               fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic               fifo_empty;
    logic               accept, legal, wr_en, pop;
    logic [BEAT_W-1:0]  cnt_q, cnt_d;
    logic [BEAT_W-1:0]  act_beats_q, act_beats_d;
    logic [TAG_W-1:0]   act_tag_q, act_tag_d;
    logic [ROUTE_W-1:0] ctrl_d;
    logic [TAG_W-1:0]   evt_tag_d;
    logic               done_d, err_d, busy_d, ready_d;

    assign in_cmd     = cmd_t'(s_cmd_tdata);
    assign head       = fifo_mem[rd_ptr_q];
    assign fifo_empty = (occ_q == '0);

    // Descriptors are checked on the way in; illegal ones are consumed but dropped
    assign accept = s_cmd_tvalid & s_cmd_tready;
    assign legal  = (in_cmd.route[2:0] >= 3'd1) && (in_cmd.route[2:0] <= 3'd5)
                    && (in_cmd.beats != '0);
    assign wr_en  = accept & legal;
    assign err_d  = accept & ~legal;

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        ctrl_d      = ctrl;
        cnt_d       = cnt_q;
        act_beats_d = act_beats_q;
        act_tag_d   = act_tag_q;
        done_d      = 1'b0;
        evt_tag_d   = evt_tag;

        if (err_d) begin
            evt_tag_d = in_cmd.tag;
        end

        case (state_q)
            IDLE: begin
                ctrl_d = '0;
                if (!fifo_empty) begin
                    pop         = 1'b1;
                    ctrl_d      = head.route;
                    act_beats_d = head.beats;
                    act_tag_d   = head.tag;
                    cnt_d       = '0;
                    state_d     = RUN;
                end
            end
            RUN: begin
                if (count_switch_tvalid) begin
                    if (cnt_q == act_beats_q - BEAT_W'(1)) begin
                        // done overrides a coincident err on evt_tag
                        done_d    = 1'b1;
                        evt_tag_d = act_tag_q;
                        cnt_d     = '0;
                        if (!fifo_empty) begin
                            pop         = 1'b1;
                            ctrl_d      = head.route;
                            act_beats_d = head.beats;
                            act_tag_d   = head.tag;
                        end else begin
                            ctrl_d  = '0;
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + BEAT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                ctrl_d  = '0;
            end
        endcase
    end

    assign occ_d   = occ_q + OCC_W'(wr_en) - OCC_W'(pop);
    assign ready_d = (occ_d != OCC_W'(FIFO_DEPTH));
    assign busy_d  = (state_d == RUN) || (occ_d != '0);

    // State, FIFO pointers and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            cnt_q        <= '0;
            act_beats_q  <= '0;
            act_tag_q    <= '0;
            ctrl         <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            evt_tag      <= '0;
            s_cmd_tready <= 1'b0;
        end else begin
            state_q      <= state_d;
            occ_q        <= occ_d;
            cnt_q        <= cnt_d;
            act_beats_q  <= act_beats_d;
            act_tag_q    <= act_tag_d;
            ctrl         <= ctrl_d;
            busy         <= busy_d;
            done         <= done_d;
            err          <= err_d;
            evt_tag      <= evt_tag_d;
            s_cmd_tready <= ready_d;
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // Storage needs no reset; occupancy gates every read
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            fifo_mem[wr_ptr_q] <= in_cmd;
        end
    end

endmodule
